// File: rtl/game_io_pkg.sv
// Shared definitions for the game I/O interrupt controller: register offsets, source bits,
// FSM encoding and the fixed-priority picker.
package game_io_pkg;

  localparam logic [7:0] RegStatus   = 8'd0;
  localparam logic [7:0] RegMask     = 8'd1;
  localparam logic [7:0] RegCause    = 8'd2;
  localparam logic [7:0] RegTickCtrl = 8'd3;
  localparam logic [7:0] RegOverrun  = 8'd4;
  localparam logic [7:0] NumRegs     = 8'd5;

  localparam int unsigned SrcTick = 0;
  localparam int unsigned SrcColl = 1;
  localparam int unsigned SrcBtn  = 2;
  localparam int unsigned SrcExt  = 3;

  localparam int unsigned TickDivDefault = 50_000_000;
  localparam int unsigned TICK_W         = $clog2(TickDivDefault);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StService = 2'd2
  } irq_state_e;

  // Highest first: collision, tick, ext, button.
  function automatic logic [3:0] prio_pick(input logic [3:0] req);
    logic [3:0] one_hot;
    one_hot = '0;
    if (req[SrcColl])      one_hot[SrcColl] = 1'b1;
    else if (req[SrcTick]) one_hot[SrcTick] = 1'b1;
    else if (req[SrcExt])  one_hot[SrcExt]  = 1'b1;
    else if (req[SrcBtn])  one_hot[SrcBtn]  = 1'b1;
    return one_hot;
  endfunction

endpackage

// File: rtl/game_irq_ctrl_if.sv
// KCPSM6-side port bus and interrupt handshake of the game interrupt controller.
interface game_irq_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] irq_rdata;
  logic       irq_rsel;

  modport master (
    output port_id, out_port, write_strobe, interrupt_ack,
    input  interrupt, irq_rdata, irq_rsel
  );

  modport slave (
    input  port_id, out_port, write_strobe, interrupt_ack,
    output interrupt, irq_rdata, irq_rsel
  );
endinterface

// File: rtl/game_irq_ctrl_tick.sv
// Game tick counter: counts while enabled, wraps at TICK_DIV-1 with a one-cycle wrap pulse.
module game_tick_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned Width    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam logic [Width-1:0] Last = Width'(TICK_DIV - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && !clr && (cnt_q == Last);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_irq_ctrl.sv
// Interrupt controller for KCPSM6: latches four event sources, masks, arbitrates by fixed
// priority and runs the interrupt/ack/EOI handshake behind a small port-mapped window.
module game_irq_ctrl
  import game_io_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [7:0]  BASE_PORT = 8'h10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             collision_detect,
  input  logic [3:0]       db_btns,
  input  logic             irq_ext,
  game_irq_ctrl_if.slave   bus
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic       coll_q, ext_q;
  logic [3:0] btns_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] cause_q, cause_d;
  logic [3:0] overrun_q, overrun_d;
  logic       tick_en_q, tick_en_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rsel_q;
  irq_state_e state_q, state_d;

  logic [3:0] ev, claim, status_clr, ovr_clr;
  logic [7:0] off;
  logic       in_win, tick_wrap, irq;
  logic       wr_status, wr_mask, wr_cause, wr_tick, wr_overrun, eoi;

  game_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .Width    (TickW)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en_q),
    .clr  (wr_tick),
    .wrap (tick_wrap)
  );

  // Offset arithmetic wraps, so anything below BASE_PORT lands far outside the window.
  assign off    = bus.port_id - BASE_PORT;
  assign in_win = off < NumRegs;

  assign wr_status  = bus.write_strobe && (off == RegStatus);
  assign wr_mask    = bus.write_strobe && (off == RegMask);
  assign wr_cause   = bus.write_strobe && (off == RegCause);
  assign wr_tick    = bus.write_strobe && (off == RegTickCtrl);
  assign wr_overrun = bus.write_strobe && (off == RegOverrun);
  assign eoi        = wr_cause;

  always_comb begin
    ev          = '0;
    ev[SrcTick] = tick_wrap;
    ev[SrcColl] = collision_detect && !coll_q;
    ev[SrcBtn]  = |(db_btns & ~btns_q);
    ev[SrcExt]  = irq_ext && !ext_q;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    claim   = '0;
    irq     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|(pending_q & mask_q)) begin
          claim   = prio_pick(pending_q & mask_q);
          cause_d = claim;
          state_d = StAssert;
        end
      end
      StAssert: begin
        irq = 1'b1;
        if (bus.interrupt_ack) state_d = StService;
      end
      StService: begin
        if (eoi) begin
          cause_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh event always wins over a clear; a bit being cleared or claimed is not an overrun.
  always_comb begin
    status_clr = wr_status  ? bus.out_port[3:0] : 4'b0;
    ovr_clr    = wr_overrun ? bus.out_port[3:0] : 4'b0;
    pending_d  = (pending_q & ~status_clr & ~claim) | ev;
    overrun_d  = (overrun_q & ~ovr_clr) | (ev & pending_q & ~status_clr & ~claim);
    mask_d     = wr_mask ? bus.out_port[3:0] : mask_q;
    tick_en_d  = wr_tick ? bus.out_port[0] : tick_en_q;
  end

  always_comb begin
    rdata_d = '0;
    if (in_win) begin
      case (off)
        RegStatus:   rdata_d = {4'b0, pending_q};
        RegMask:     rdata_d = {4'b0, mask_q};
        RegCause:    rdata_d = {4'b0, cause_q};
        RegTickCtrl: rdata_d = {7'b0, tick_en_q};
        RegOverrun:  rdata_d = {4'b0, overrun_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q    <= 1'b0;
      btns_q    <= '0;
      ext_q     <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= '0;
      overrun_q <= '0;
      tick_en_q <= 1'b0;
      rdata_q   <= '0;
      rsel_q    <= 1'b0;
      state_q   <= StIdle;
    end else begin
      coll_q    <= collision_detect;
      btns_q    <= db_btns;
      ext_q     <= irq_ext;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      overrun_q <= overrun_d;
      tick_en_q <= tick_en_d;
      rdata_q   <= rdata_d;
      rsel_q    <= in_win;
      state_q   <= state_d;
    end
  end

  assign bus.interrupt = irq;
  assign bus.irq_rdata = rdata_q;
  assign bus.irq_rsel  = rsel_q;

endmodule

// File: doc/game_irq_ctrl.md
# game_irq_ctrl

Interrupt controller and scheduler for the KCPSM6 `interrupt` / `interrupt_ack` pair in the game I/O subsystem. It collects four event sources: game tick timer, collision, button press and an external spare. It latches them as pending, masks them, arbitrates them by fixed priority and presents one interrupt at a time to the processor. Firmware reads status and cause and ends service through a small port-mapped register window at 0x10–0x14, muxed into `in_port` by the game I/O block.

## Interface
Parameters:
- TICK_DIV, 50_000_000, tick period in clk cycles; the tick counter wraps at TICK_DIV-1.
- BASE_PORT, 8'h10, first port_id of the register window.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- collision_detect  in  1  level collision flag, synchronous to clk.
- db_btns  in  4  debounced buttons.
- irq_ext  in  1  spare event, level input.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- write_strobe  in  1  KCPSM6 write strobe.
- interrupt  out  1  interrupt request to KCPSM6.
- interrupt_ack  in  1  KCPSM6 acknowledge, one-cycle pulse.
- irq_rdata  out  8  registered read data for the window.
- irq_rsel  out  1  registered; 1 when the previous cycle's port_id was inside the window.

## Operation
- Source bits: 0 = tick, 1 = collision (rising edge), 2 = button (rising edge on any db_btns bit), 3 = ext (rising edge).
- Edge detection uses a one-cycle registered copy of each input.
- Registers, at BASE_PORT+n:
  - +0 STATUS: pending[3:0]. Reads return pending. Writing is write-1-to-clear.
  - +1 MASK: rw, bits [3:0]; 1 enables the source.
  - +2 CAUSE: one-hot cause of the current interrupt, read-only. Any write to this address is EOI.
  - +3 TICK_CTRL: bit0 enables the tick counter. Any write clears the counter.
  - +4 OVERRUN: sticky per source, write-1-to-clear. A bit sets when an event arrives while that pending bit is already 1.
- Upper bits of every register read as 0.
- Event and write-1-to-clear on the same cycle: set wins, and overrun is not set.
- Priority, highest first: collision, tick, ext, button.
- FSM states:
  - IDLE: when (pending & mask) ≠ 0, latch CAUSE as the highest-priority bit, clear that pending bit, and go to ASSERT.
  - ASSERT: interrupt = 1. Go to SERVICE on interrupt_ack.
  - SERVICE: interrupt = 0. Go to IDLE on EOI, and CAUSE clears to 0.
- An EOI written outside SERVICE is ignored.
- Changing MASK or STATUS in ASSERT or SERVICE does not affect the latched CAUSE.
- Tick counter: counts only while enabled. At TICK_DIV-1 it wraps to 0 and raises a tick event. When disabled it holds its value.

## Timing
- Reset values: interrupt = 0, irq_rdata = 0, irq_rsel = 0, all registers 0 (everything masked, tick disabled), FSM = IDLE, edge registers = 0.
- Reset mid-operation drops interrupt on the next edge, with no ack required.
- Input edge at clock edge k: pending set at k+1.
- IDLE with an enabled pending bit at edge j: interrupt = 1 and CAUSE valid at j+1.
- interrupt_ack sampled at edge a: interrupt = 0 at a+1.
- EOI at edge e: IDLE at e+1. A still-pending enabled source re-asserts interrupt at e+2.
- Register writes take effect at the edge where write_strobe = 1.
- irq_rdata and irq_rsel update every cycle from port_id, so they are valid one cycle after port_id. This meets KCPSM6 INPUT timing.
- An ack arriving outside ASSERT is ignored.

## Structure
- Shared package `game_io_pkg`:
  - register offsets (STATUS/MASK/CAUSE/TICK_CTRL/OVERRUN);
  - source bit indices;
  - FSM state encoding (IDLE/ASSERT/SERVICE, 2 bits);
  - TICK_W = $clog2(TICK_DIV).
- Sub-module `game_tick_timer`: enable, clear, wrap pulse.
- The edge detect, the register file and the FSM stay in the top module.

## Test plan
- Reset, then pulse collision_detect with MASK = 0 → STATUS reads 0x02 and interrupt stays 0. Write MASK = 0x02 → interrupt = 1 two cycles later and CAUSE = 0x02.
- Collision and btns[0] rise in the same cycle with MASK = 0x0F → first CAUSE = 0x02. After ack and EOI, the second interrupt has CAUSE = 0x04.
- TICK_DIV = 10, TICK_CTRL = 1, MASK = 0x01 → interrupt every 10 cycles while serviced promptly. A second tick before EOI sets STATUS bit0. A third tick sets OVERRUN = 0x01.
- Write STATUS = 0x08 on the same cycle irq_ext rises → pending bit3 stays 1 and OVERRUN bit3 stays 0.
- Assert rst while in ASSERT → interrupt = 0 next cycle and all registers read 0. An EOI write in IDLE has no effect.
- port_id = 0x11 → irq_rsel = 1 and irq_rdata = MASK one cycle later. port_id = 0x20 → irq_rsel = 0.
